// File: rtl/core_if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package core_if_pkg;

  localparam int IF_WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant memory bus. Read data returns one cycle after grant.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data
  );
endinterface

// File: rtl/core_if_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with flush.
// Flush wins over a same-cycle push or pop.
module core_if_fifo
  import core_if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign push_en = push & ~flush;
  assign pop_en  = pop & ~flush;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/core_if_prefetch.sv
// Instruction-fetch stage with prefetch queue in front of decode.
// Optional: CORE_IF_PERF_CNT_EN adds o_stall_cnt (decode-starved cycles).
module core_if_prefetch
  import core_if_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_boot_addr,
  input  logic        i_en,
  input  logic        i_ex_jmp,
  input  logic [31:0] i_ex_jmp_target,
  input  logic        i_id_jmp,
  input  logic [31:0] i_id_jmp_target,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_next_pc,
`ifdef CORE_IF_PERF_CNT_EN
  output logic [31:0] o_stall_cnt,
`endif
  naive_bus.master    bus_master
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fpc_q, fpc_d, pend_pc_q, pend_pc_d;
  logic          inflight_q, inflight_d, drop_q, drop_d;
  logic          redir, pop, push, grant, rd_req;
  logic [31:0]   jmp_tgt, req_addr;
  logic [CW:0]   occ;
  fetch_entry_t  head, din;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;

  // Redirect select, request decision and next fetch PC.
  always_comb begin
    redir    = i_ex_jmp | i_id_jmp;
    jmp_tgt  = word_align(i_ex_jmp ? i_ex_jmp_target : i_id_jmp_target);
    req_addr = redir ? jmp_tgt : fpc_q;
    pop      = i_en & ~fifo_empty & ~redir;
    // Queued + in-flight after this cycle's pop must leave room for a new word.
    occ      = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    rd_req   = redir | (occ < DEPTH_V);
    grant    = rd_req & bus_master.rd_gnt;
    fpc_d    = grant ? req_addr + 32'(IF_WORD_BYTES) : req_addr;
    inflight_d = grant;
    pend_pc_d  = grant ? req_addr : pend_pc_q;
    // A redirect that was not itself granted leaves nothing fresh in flight.
    drop_d   = redir & ~grant;
    // A response landing in a redirect cycle belongs to the old stream.
    push     = inflight_q & ~drop_q & ~redir & ~fifo_full;
  end

  // Fetch PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= word_align(i_boot_addr);
      pend_pc_q  <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      pend_pc_q  <= pend_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign din = '{pc: pend_pc_q, instr: bus_master.rd_data};

  core_if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (din),
    .head  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus_master.rd_req  = rd_req;
  assign bus_master.rd_addr = rd_req ? req_addr : 32'h0;
  assign bus_master.rd_be   = rd_req ? 4'hF : 4'h0;
  assign bus_master.wr_req  = 1'b0;
  assign bus_master.wr_be   = 4'h0;
  assign bus_master.wr_addr = 32'h0;
  assign bus_master.wr_data = 32'h0;

  assign o_valid   = ~fifo_empty;
  assign o_instr   = o_valid ? head.instr : BUBBLE_INSTR;
  assign o_pc      = o_valid ? head.pc : fpc_q;
  assign o_next_pc = o_pc + 32'(IF_WORD_BYTES);

`ifdef CORE_IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles decode wanted an instruction and got none.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_en & ~o_valid & ~redir & ~(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_core_if_prefetch.sv
// Directed bench for core_if_prefetch. Memory model returns ~addr as data.
module tb_core_if_prefetch;
  localparam logic [31:0] BUB = 32'hDEAD_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] boot = 32'h0;
  logic        en = 1'b0, ex_jmp = 1'b0, id_jmp = 1'b0;
  logic [31:0] ex_tgt = 32'h0, id_tgt = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr, o_pc, o_next_pc;
`ifdef CORE_IF_PERF_CNT_EN
  logic [31:0] o_stall_cnt;
`endif
  int total = 0, bad = 0;

  naive_bus bus ();

  core_if_prefetch #(.FIFO_DEPTH(4), .BUBBLE_INSTR(BUB)) dut (
    .clk(clk), .rst_n(rst_n), .i_boot_addr(boot), .i_en(en),
    .i_ex_jmp(ex_jmp), .i_ex_jmp_target(ex_tgt),
    .i_id_jmp(id_jmp), .i_id_jmp_target(id_tgt),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_next_pc(o_next_pc),
`ifdef CORE_IF_PERF_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .bus_master(bus)
  );

  always #5 clk = ~clk;

  // Memory: data for a granted address appears the next cycle.
  initial bus.rd_data = 32'h0;
  always @(posedge clk) if (bus.rd_req && bus.rd_gnt) bus.rd_data <= ~bus.rd_addr;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    boot = 32'h0000_1003; en = 1'b1; bus.rd_gnt = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    total++; if (o_instr !== BUB) begin bad++; $display("FAIL rst_instr got %h exp %h", o_instr, BUB); end
    total++; if (o_pc !== 32'h1000) begin bad++; $display("FAIL rst_pc got %h exp 00001000", o_pc); end
    total++; if (o_next_pc !== 32'h1004) begin bad++; $display("FAIL rst_next_pc got %h exp 00001004", o_next_pc); end
    total++;
    if ({bus.wr_req, bus.wr_be, bus.wr_addr, bus.wr_data} !== 69'h0) begin
      bad++; $display("FAIL rst_wr_port got %b/%h/%h/%h exp zeros", bus.wr_req, bus.wr_be, bus.wr_addr, bus.wr_data);
    end
`ifdef CORE_IF_PERF_CNT_EN
    total++; if (o_stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall_cnt got %0d exp 0", o_stall_cnt); end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      e = 32'h1000 + 32'(4 * c);
      total++;
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== e || bus.rd_be !== 4'hF) begin
        bad++; $display("FAIL seq_req c=%0d got req=%b addr=%h be=%h exp 1/%h/f", c, bus.rd_req, bus.rd_addr, bus.rd_be, e);
      end
      if (c < 2) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL seq_early_valid c=%0d got %b exp 0", c, o_valid); end
      end else begin
        e = 32'h1000 + 32'(4 * (c - 2));
        total++;
        if (o_valid !== 1'b1 || o_pc !== e || o_instr !== ~e || o_next_pc !== e + 32'd4) begin
          bad++; $display("FAIL seq_out c=%0d got v=%b pc=%h ins=%h npc=%h exp pc=%h", c, o_valid, o_pc, o_instr, o_next_pc, e);
        end
      end
      step();
    end
  endtask

  task automatic test_gnt_stall();
    logic [11:0] gtab;
    logic [31:0] exp_addr, exp_pc;
    int n;
    gtab = 12'b1111_1110_0011;
    exp_addr = 32'h2000; exp_pc = 32'h2000; n = 0;
    id_tgt = 32'h2000; en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      id_jmp = (k == 0);
      bus.rd_gnt = gtab[k];
      #1;
      total++;
      if (bus.rd_addr !== exp_addr) begin bad++; $display("FAIL stall_addr k=%0d got %h exp %h", k, bus.rd_addr, exp_addr); end
      if (gtab[k]) exp_addr = exp_addr + 32'd4;
      if (k > 0 && o_valid) begin
        total++;
        if (o_pc !== exp_pc || o_instr !== ~exp_pc) begin
          bad++; $display("FAIL stall_pc k=%0d got pc=%h ins=%h exp pc=%h", k, o_pc, o_instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4; n++;
      end
      if (k == 4) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_gap got %b exp 0", o_valid); end
      end
      step();
    end
    id_jmp = 1'b0; bus.rd_gnt = 1'b1;
    total++; if (n !== 7) begin bad++; $display("FAIL stall_count got %0d exp 7", n); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    id_tgt = 32'h3000; bus.rd_gnt = 1'b1;
    for (int k = 0; k < 16; k++) begin
      id_jmp = (k == 0);
      en = (k >= 10);
      #1;
      if (k < 10) begin
        total++;
        if (bus.rd_req !== (k < 4)) begin bad++; $display("FAIL bp_req k=%0d got %b exp %b", k, bus.rd_req, (k < 4)); end
      end
      if (k == 5) begin
        total++;
        if (bus.rd_addr !== 32'h0 || bus.rd_be !== 4'h0) begin
          bad++; $display("FAIL bp_idle_bus got addr=%h be=%h exp 0/0", bus.rd_addr, bus.rd_be);
        end
      end
      if (k >= 10) begin
        e = 32'h3000 + 32'(4 * (k - 10));
        total++;
        if (o_valid !== 1'b1 || o_pc !== e || o_instr !== ~e) begin
          bad++; $display("FAIL bp_resume k=%0d got v=%b pc=%h ins=%h exp pc=%h", k, o_valid, o_pc, o_instr, e);
        end
      end
      step();
    end
    id_jmp = 1'b0;
  endtask

  task automatic test_dual_jump();
    logic [31:0] e;
    id_tgt = 32'h300; ex_tgt = 32'h400; en = 1'b1; bus.rd_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id_jmp = (k == 0); ex_jmp = (k == 0);
      #1;
      if (k == 0) begin
        total++; if (bus.rd_addr !== 32'h400) begin bad++; $display("FAIL dual_addr got %h exp 00000400", bus.rd_addr); end
      end else if (k == 1) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL dual_bubble got %b exp 0", o_valid); end
      end else begin
        e = 32'h400 + 32'(4 * (k - 2));
        total++;
        if (o_valid !== 1'b1 || o_pc !== e || o_instr !== ~e) begin
          bad++; $display("FAIL dual_out k=%0d got v=%b pc=%h ins=%h exp pc=%h", k, o_valid, o_pc, o_instr, e);
        end
      end
      step();
    end
    id_jmp = 1'b0; ex_jmp = 1'b0;
  endtask

  task automatic test_drop();
    id_tgt = 32'h50; ex_tgt = 32'h600; en = 1'b1; bus.rd_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id_jmp = (k == 0); ex_jmp = (k == 1);
      #1;
      case (k)
        0: begin total++; if (bus.rd_addr !== 32'h50) begin bad++; $display("FAIL drop_req got %h exp 00000050", bus.rd_addr); end end
        1: begin total++; if (bus.rd_addr !== 32'h600) begin bad++; $display("FAIL drop_redir got %h exp 00000600", bus.rd_addr); end end
        2: begin total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL drop_stale got v=%b pc=%h exp v=0", o_valid, o_pc); end end
        default: begin
          total++;
          if (o_valid !== 1'b1 || o_pc !== 32'h600 || o_instr !== ~32'h600) begin
            bad++; $display("FAIL drop_target got v=%b pc=%h ins=%h exp pc=00000600", o_valid, o_pc, o_instr);
          end
        end
      endcase
      step();
    end
    id_jmp = 1'b0; ex_jmp = 1'b0;
  endtask

  task automatic test_reset_mid();
    boot = 32'h0000_8002; en = 1'b1; bus.rd_gnt = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_instr !== BUB || o_pc !== 32'h8000 || o_next_pc !== 32'h8004) begin
      bad++; $display("FAIL mid_rst got v=%b ins=%h pc=%h npc=%h exp 0/%h/00008000/00008004", o_valid, o_instr, o_pc, o_next_pc, BUB);
    end
`ifdef CORE_IF_PERF_CNT_EN
    total++; if (o_stall_cnt !== 32'h0) begin bad++; $display("FAIL mid_rst_cnt got %0d exp 0", o_stall_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
`ifdef CORE_IF_PERF_CNT_EN
    bus.rd_gnt = 1'b0;
    repeat (5) step();
    #1;
    total++; if (o_stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt got %0d exp 5", o_stall_cnt); end
    bus.rd_gnt = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 0) begin
        total++; if (bus.rd_addr !== 32'h8000) begin bad++; $display("FAIL mid_addr got %h exp 00008000", bus.rd_addr); end
      end else if (k == 1) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got v=%b pc=%h exp v=0", o_valid, o_pc); end
      end else begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h8000 || o_instr !== ~32'h8000) begin
          bad++; $display("FAIL mid_first got v=%b pc=%h ins=%h exp pc=00008000", o_valid, o_pc, o_instr);
        end
      end
      step();
    end
  endtask

  initial begin
    bus.rd_gnt = 1'b0;
    test_reset();
    test_sequential();
    test_gnt_stall();
    test_backpressure();
    test_dual_jump();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
